// File: rtl/arbiter_8x3_round_robin.sv
// Eight-requester round-robin arbiter with a two-state grant FSM and a bounded hold time.
// All outputs are registered; a forced release after MAX_HOLD cycles raises a one-cycle timeout pulse.
module arbiter_8x3_round_robin #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  ptr, ptr_nxt;
    logic [7:0]  hold_cnt, hold_cnt_nxt;
    logic [7:0]  gnt_nxt;
    logic [2:0]  gnt_idx_nxt;
    logic        gnt_valid_nxt;
    logic        timeout_nxt;
    logic        user_release;
    logic        hold_limit;
    logic [2:0]  winner;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // Scan from the highest offset down so the last hit is the one nearest ptr.
    function automatic logic [2:0] find_winner(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] win;
        logic [2:0] idx;
        win = 3'd0;
        for (int off = 7; off >= 0; off--) begin
            idx = p + 3'(off);
            if (r[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    assign winner       = find_winner(req, ptr);
    assign user_release = done || !req[gnt_idx];
    assign hold_limit   = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = hold_cnt;
        gnt_nxt       = gnt;
        gnt_idx_nxt   = gnt_idx;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req != 8'h00) begin
                    state_nxt     = GRANT;
                    hold_cnt_nxt  = 8'd0;
                    gnt_nxt       = 8'd1 << winner;
                    gnt_idx_nxt   = winner;
                    gnt_valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (user_release || hold_limit) begin
                    state_nxt     = IDLE;
                    ptr_nxt       = gnt_idx + 3'd1;
                    hold_cnt_nxt  = 8'd0;
                    gnt_nxt       = 8'h00;
                    gnt_idx_nxt   = 3'd0;
                    gnt_valid_nxt = 1'b0;
                    // Only a release caused purely by the hold limit counts as a timeout.
                    timeout_nxt   = !user_release;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= 8'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_arbiter_8x3_round_robin.sv
// Directed plus randomized bench for the round-robin arbiter, checked against a
// holder/pointer reference model evaluated once per clock edge.
module tb_arbiter_8x3_round_robin;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the resource (-1 = nobody), cycles held, next-search start.
    int holder = -1;
    int held   = 0;
    int mptr   = 0;
    bit mto    = 1'b0;

    arbiter_8x3_round_robin #(.MAX_HOLD(MAXH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        mto = 1'b0;
        if (!rst_n) begin
            holder = -1;
            held   = 0;
            mptr   = 0;
        end else if (holder < 0) begin
            for (int k = 0; k < 8; k++) begin
                if (holder < 0 && req[(mptr + k) % 8]) holder = (mptr + k) % 8;
            end
            held = 1;
        end else if (done || !req[holder]) begin
            mptr   = (holder + 1) % 8;
            holder = -1;
        end else if (held >= MAXH) begin
            mptr   = (holder + 1) % 8;
            holder = -1;
            mto    = 1'b1;
        end else begin
            held++;
        end
    endtask

    task automatic step();
        logic [7:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (holder >= 0) ? (8'd1 << holder) : 8'h00;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_idx", 32'(gnt_idx), (holder >= 0) ? 32'(holder) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), (holder >= 0) ? 32'd1 : 32'd0);
        chk("timeout", 32'(timeout), 32'(mto));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int order27[4];
        int vcnt;
        order27 = '{7, 0, 7, 0};
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset_valid", 32'(gnt_valid), 32'd0);

        // Single requester grant and done release.
        req = 8'h01;
        step();
        chk("r26_gnt", 32'(gnt), 32'h01);
        done = 1'b1;
        step();
        chk("r26_rel", 32'(gnt_valid), 32'd0);
        done = 1'b0;
        req  = 8'h00;
        step();

        // Pointer sits at 1, so 7 wins first, then alternation.
        req = 8'h81;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("r27_idx", 32'(gnt_idx), 32'(order27[k]));
            done = 1'b1;
            step();
            chk("r27_gap", 32'(gnt_valid), 32'd0);
            done = 1'b0;
        end

        // Full request vector walks every index and wraps.
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("r28_idx", 32'(gnt_idx), 32'(k % 8));
            done = 1'b1;
            step();
            done = 1'b0;
        end

        // Hold-limit forced release.
        do_reset();
        req = 8'h10;
        step();
        vcnt = 0;
        for (int i = 0; i < 20 && gnt_valid; i++) begin
            vcnt++;
            step();
        end
        chk("r29_hold", 32'(vcnt), 32'(MAXH));
        chk("r29_to", 32'(timeout), 32'd1);
        chk("r29_gnt", 32'(gnt), 32'd0);
        step();
        chk("r29_to_pulse", 32'(timeout), 32'd0);

        // Requester 3 withdraws; pointer moves to 4.
        do_reset();
        req = 8'h08;
        step();
        chk("r30_idx", 32'(gnt_idx), 32'd3);
        req = 8'h00;
        step();
        chk("r30_valid", 32'(gnt_valid), 32'd0);
        chk("r30_to", 32'(timeout), 32'd0);
        req = 8'hFF;
        step();
        chk("r30_next", 32'(gnt_idx), 32'd4);

        // Reset during a grant drops it and returns the pointer to 0.
        do_reset();
        req = 8'h20;
        step();
        chk("r31_idx", 32'(gnt_idx), 32'd5);
        rst_n = 1'b0;
        step();
        chk("r31_valid", 32'(gnt_valid), 32'd0);
        chk("r31_to", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        req   = 8'h21;
        step();
        chk("r31_regrant", 32'(gnt_idx), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done  = ($urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
